// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin SDRAM arbiter: FSM state encoding and
// the beat-counter width derived from the burst length.
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter width for a burst of the given length; never narrower than one bit.
    function automatic int beat_w(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requester with req high, starting at ptr and
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IN = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IN-1:0] ptr,
    output logic [IN-1:0] index,
    output logic          any
);

    int          j;
    logic [IN-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        index = '0;
        any   = |req;
        j     = 0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            cand = IN'(j);
            if (req[cand]) index = cand;
        end
    end

endmodule

// File: rtl/arbiter_rr.sv
// Round-robin arbiter granting N requesters access to one SDRAM controller
// port; read returns are routed back by id independently of the grant logic.
module arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int N     = 4,
    parameter int IN    = 2,
    parameter int BURST = 8
) (
    input  logic            clkSYS,
    input  logic            n_reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    wr,
    input  logic [N*AN-1:0] addr,
    input  logic [N*DN-1:0] data,
    output logic [N-1:0]    ack,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [AN-1:0]   mem_addr,
    output logic [DN-1:0]   mem_data,
    output logic [IN-1:0]   mem_id,
    input  logic            mem_ack,
    input  logic            mem_valid,
    input  logic [IN-1:0]   mem_rid,
    input  logic [DN-1:0]   mem_rdata,
    output logic [N-1:0]    valid,
    output logic [DN-1:0]   rdata,
    output logic            dbg_state
);

    localparam int CW = beat_w(BURST);

    state_t        state, next_state;
    logic [IN-1:0] grant, ptr, pick;
    logic [CW-1:0] beat;
    logic          any, g_req, g_wr, ack_hit, done, end_tx;

    rr_pick #(.N(N), .IN(IN)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .index (pick),
        .any   (any)
    );

    assign g_req    = req[grant];
    assign g_wr     = wr[grant];
    assign mem_req  = (state == GRANT) && g_req;
    assign mem_wr   = g_wr;
    assign mem_addr = addr[int'(grant)*AN +: AN];
    assign mem_data = data[int'(grant)*DN +: DN];
    assign mem_id   = grant;

    // mem_ack only counts while a request is actually presented.
    assign ack_hit = mem_req && mem_ack;
    assign ack     = {N{ack_hit}} & (N'(1) << grant);
    assign done    = ack_hit && (!g_wr || (beat == CW'(BURST - 1)));
    assign end_tx  = (state == GRANT) && (!g_req || done);

    assign dbg_state = logic'(state);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any) next_state = GRANT;
            GRANT:   if (end_tx) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            grant <= '0;
            ptr   <= '0;
            beat  <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                grant <= pick;
                beat  <= '0;
            end
        end else if (end_tx) begin
            // Completion and abort both hand priority to the next requester.
            ptr  <= (int'(grant) == N - 1) ? '0 : grant + IN'(1);
            beat <= '0;
        end else if (ack_hit && g_wr) begin
            beat <= beat + CW'(1);
        end
    end

    always_comb begin
        valid = '0;
        for (int i = 0; i < N; i++) begin
            valid[i] = mem_valid && (int'(mem_rid) == i);
        end
    end

    assign rdata = mem_rdata;

endmodule
